// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller for a 5-stage in-order core: decides PC/IF-ID
// freezes, flush and bubble insertion, and keeps stall performance/timeout status.
module pipe_stall_ctrl #(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 8
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst_n,
    input  logic             i_hazard_detected,
    input  logic             i_branch_taken,
    input  logic             i_mem_busy,
    input  logic             i_cnt_clr,
    output logic             o_pc_freeze,
    output logic             o_ifid_freeze,
    output logic             o_ifid_flush,
    output logic             o_idex_bubble,
    output logic             o_mem_hold,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic             o_stall_timeout
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HAZ_STALL = 2'd1,
        ST_MEM_WAIT  = 2'd2,
        ST_FLUSH     = 2'd3
    } state_e;

    localparam logic [7:0]       MAX_STALL_C = 8'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_MAX_C   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_r;
    state_e           state_nxt_s;
    logic             hazard_en_s;
    logic             hazard_stall_s;
    logic [7:0]       consec_r;
    logic [7:0]       consec_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic             timeout_r;

    // Hazards are ignored in FLUSH: the ID slot already holds a flushed bubble.
    always_comb begin
        hazard_en_s = 1'b1;
        case (state_r)
            ST_RUN:       hazard_en_s = 1'b1;
            ST_HAZ_STALL: hazard_en_s = 1'b1;
            ST_MEM_WAIT:  hazard_en_s = 1'b1;
            ST_FLUSH:     hazard_en_s = 1'b0;
            default:      hazard_en_s = 1'b1;
        endcase
    end

    // Prioritised control decode (mem_busy > branch > hazard) and next state.
    always_comb begin
        o_pc_freeze    = 1'b0;
        o_ifid_freeze  = 1'b0;
        o_ifid_flush   = 1'b0;
        o_idex_bubble  = 1'b0;
        o_mem_hold     = 1'b0;
        hazard_stall_s = 1'b0;
        state_nxt_s    = ST_RUN;
        if (i_mem_busy) begin
            o_pc_freeze   = 1'b1;
            o_ifid_freeze = 1'b1;
            o_mem_hold    = 1'b1;
            state_nxt_s   = ST_MEM_WAIT;
        end else if (i_branch_taken) begin
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
            state_nxt_s   = ST_FLUSH;
        end else if (i_hazard_detected && hazard_en_s) begin
            o_pc_freeze    = 1'b1;
            o_ifid_freeze  = 1'b1;
            o_idex_bubble  = 1'b1;
            hazard_stall_s = 1'b1;
            state_nxt_s    = ST_HAZ_STALL;
        end else begin
            state_nxt_s = ST_RUN;
        end
    end

    // State register.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Consecutive hazard-stall length, saturating at the timeout threshold.
    always_comb begin
        consec_nxt_s = 8'd0;
        if (hazard_stall_s) begin
            if (consec_r < MAX_STALL_C) begin
                consec_nxt_s = consec_r + 8'd1;
            end else begin
                consec_nxt_s = consec_r;
            end
        end else begin
            consec_nxt_s = 8'd0;
        end
    end

    // Consecutive hazard counter register.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            consec_r <= 8'd0;
        end else begin
            consec_r <= consec_nxt_s;
        end
    end

    // Saturating count of frozen-PC cycles; clear wins over increment.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (i_cnt_clr) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (o_pc_freeze && (stall_cnt_r != CNT_MAX_C)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE_C;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Sticky timeout, raised on the edge the stall length reaches MAX_STALL.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            timeout_r <= 1'b0;
        end else if (i_cnt_clr) begin
            timeout_r <= 1'b0;
        end else if (hazard_stall_s && (consec_nxt_s == MAX_STALL_C)) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign o_state         = state_r;
    assign o_stall_cnt     = stall_cnt_r;
    assign o_stall_timeout = timeout_r;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl (default instance plus a
// CNT_W=4 instance sharing the same stimulus for counter saturation).
module tb_pipe_stall_ctrl;

    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_HAZ  = 5'b11010;
    localparam logic [4:0] C_BR   = 5'b00110;
    localparam logic [4:0] C_MEM  = 5'b11001;

    logic        i_sys_clk;
    logic        i_sys_rst_n;
    logic        hazard, branch, mem_busy, cnt_clr;
    logic        pc_freeze, ifid_freeze, ifid_flush, idex_bubble, mem_hold;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic        timeout;
    logic        pc_freeze4, ifid_freeze4, ifid_flush4, idex_bubble4, mem_hold4;
    logic [1:0]  state4;
    logic [3:0]  stall_cnt4;
    logic        timeout4;
    logic [4:0]  ctrl_s;

    int num_checks = 0;
    int num_errors = 0;

    assign ctrl_s = {pc_freeze, ifid_freeze, ifid_flush, idex_bubble, mem_hold};

    pipe_stall_ctrl u_dut (
        .i_sys_clk(i_sys_clk), .i_sys_rst_n(i_sys_rst_n),
        .i_hazard_detected(hazard), .i_branch_taken(branch),
        .i_mem_busy(mem_busy), .i_cnt_clr(cnt_clr),
        .o_pc_freeze(pc_freeze), .o_ifid_freeze(ifid_freeze),
        .o_ifid_flush(ifid_flush), .o_idex_bubble(idex_bubble),
        .o_mem_hold(mem_hold), .o_state(state),
        .o_stall_cnt(stall_cnt), .o_stall_timeout(timeout)
    );

    pipe_stall_ctrl #(.CNT_W(4), .MAX_STALL(8)) u_dut4 (
        .i_sys_clk(i_sys_clk), .i_sys_rst_n(i_sys_rst_n),
        .i_hazard_detected(hazard), .i_branch_taken(branch),
        .i_mem_busy(mem_busy), .i_cnt_clr(cnt_clr),
        .o_pc_freeze(pc_freeze4), .o_ifid_freeze(ifid_freeze4),
        .o_ifid_flush(ifid_flush4), .o_idex_bubble(idex_bubble4),
        .o_mem_hold(mem_hold4), .o_state(state4),
        .o_stall_cnt(stall_cnt4), .o_stall_timeout(timeout4)
    );

    initial i_sys_clk = 1'b0;
    always #5 i_sys_clk = ~i_sys_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge i_sys_clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        i_sys_rst_n = 1'b0;
        hazard = 1'b0; branch = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
        tick();
        settle();
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_cnt", 32'(stall_cnt), 32'd0);
        check_val("rst_timeout", 32'(timeout), 32'd0);
        check_val("rst_ctrl_idle", 32'(ctrl_s), 32'(C_NONE));
        hazard = 1'b1;
        settle();
        check_val("rst_ctrl_live_haz", 32'(ctrl_s), 32'(C_HAZ));
        tick();
        check_val("rst_state_held", 32'(state), 32'd0);
        hazard = 1'b0;
        i_sys_rst_n = 1'b1;
        tick();

        // Three-cycle hazard pulse from RUN.
        hazard = 1'b1;
        settle();
        check_val("haz3_c1_state", 32'(state), 32'd0);
        check_val("haz3_c1_ctrl", 32'(ctrl_s), 32'(C_HAZ));
        tick();
        check_val("haz3_c2_state", 32'(state), 32'd1);
        check_val("haz3_c2_ctrl", 32'(ctrl_s), 32'(C_HAZ));
        tick();
        check_val("haz3_c3_state", 32'(state), 32'd1);
        check_val("haz3_c3_ctrl", 32'(ctrl_s), 32'(C_HAZ));
        tick();
        hazard = 1'b0;
        settle();
        check_val("haz3_end_state", 32'(state), 32'd1);
        check_val("haz3_end_ctrl", 32'(ctrl_s), 32'(C_NONE));
        tick();
        check_val("haz3_run_state", 32'(state), 32'd0);
        check_val("haz3_cnt", 32'(stall_cnt), 32'd3);

        // Branch overrides hazard in HAZ_STALL; FLUSH ignores hazard.
        hazard = 1'b1;
        tick();
        check_val("hb_state_haz", 32'(state), 32'd1);
        branch = 1'b1;
        settle();
        check_val("hb_ctrl_flush", 32'(ctrl_s), 32'(C_BR));
        tick();
        branch = 1'b0;
        settle();
        check_val("hb_state_flush", 32'(state), 32'd3);
        check_val("hb_flush_ignores_haz", 32'(ctrl_s), 32'(C_NONE));
        tick();
        hazard = 1'b0;
        settle();
        check_val("hb_state_run", 32'(state), 32'd0);
        check_val("hb_cnt", 32'(stall_cnt), 32'd4);

        // mem_busy overlapping a hazard, then the hazard stall resumes.
        hazard = 1'b1;
        tick();
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_val($sformatf("mem_ovl_ctrl_%0d", i), 32'(ctrl_s), 32'(C_MEM));
            tick();
        end
        mem_busy = 1'b0;
        settle();
        check_val("mem_ovl_state_wait", 32'(state), 32'd2);
        check_val("mem_ovl_resume_ctrl", 32'(ctrl_s), 32'(C_HAZ));
        tick();
        check_val("mem_ovl_state_haz", 32'(state), 32'd1);
        check_val("mem_ovl_cnt", 32'(stall_cnt), 32'd10);

        // Consecutive count restarted at 1 here: 6 more edges stay below 8.
        for (int i = 0; i < 6; i++) tick();
        check_val("to_not_yet", 32'(timeout), 32'd0);
        tick();
        check_val("to_raised", 32'(timeout), 32'd1);
        check_val("to_raised_dut4", 32'(timeout4), 32'd1);
        check_val("to_cnt", 32'(stall_cnt), 32'd17);
        hazard = 1'b0;
        tick();
        check_val("to_sticky", 32'(timeout), 32'd1);
        check_val("to_state_run", 32'(state), 32'd0);
        cnt_clr = 1'b1;
        hazard = 1'b1;
        tick();
        check_val("clr_timeout", 32'(timeout), 32'd0);
        check_val("clr_beats_inc", 32'(stall_cnt), 32'd0);
        check_val("clr_fsm_unaffected", 32'(state), 32'd1);
        cnt_clr = 1'b0;
        hazard = 1'b0;
        tick();
        check_val("clr_after_state", 32'(state), 32'd0);
        check_val("clr_after_cnt", 32'(stall_cnt), 32'd0);

        // 20 frozen cycles: the 4-bit counter saturates at 15.
        mem_busy = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check_val("sat_cnt16", 32'(stall_cnt), 32'd20);
        check_val("sat_cnt4", 32'(stall_cnt4), 32'd15);
        check_val("sat_state_wait", 32'(state), 32'd2);

        // Asynchronous reset in MEM_WAIT, checked before the next edge.
        #2;
        i_sys_rst_n = 1'b0;
        settle();
        check_val("arst_state", 32'(state), 32'd0);
        check_val("arst_cnt", 32'(stall_cnt), 32'd0);
        check_val("arst_cnt4", 32'(stall_cnt4), 32'd0);
        check_val("arst_ctrl_live_mem", 32'(ctrl_s), 32'(C_MEM));
        mem_busy = 1'b0;
        tick();
        i_sys_rst_n = 1'b1;
        tick();

        // Branch -> FLUSH, mem_busy honoured in FLUSH, MEM_WAIT acts as RUN.
        branch = 1'b1;
        settle();
        check_val("br_ctrl", 32'(ctrl_s), 32'(C_BR));
        tick();
        branch = 1'b0;
        mem_busy = 1'b1;
        settle();
        check_val("fl_state", 32'(state), 32'd3);
        check_val("fl_mem_ctrl", 32'(ctrl_s), 32'(C_MEM));
        tick();
        mem_busy = 1'b0;
        branch = 1'b1;
        settle();
        check_val("mw_state", 32'(state), 32'd2);
        check_val("mw_branch_ctrl", 32'(ctrl_s), 32'(C_BR));
        tick();
        branch = 1'b0;
        settle();
        check_val("mw_to_flush", 32'(state), 32'd3);
        tick();
        check_val("final_state", 32'(state), 32'd0);
        check_val("final_cnt", 32'(stall_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the stall-cycle performance counter.
REQ-002 Parameter MAX_STALL, default 8, SHALL set the consecutive hazard-stall cycle count that raises the timeout flag (legal range 1..255).
REQ-003 i_sys_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_sys_rst_n  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 i_hazard_detected  in  1  SHALL be the data-hazard indication for the instruction in ID.
REQ-006 i_branch_taken  in  1  SHALL be the resolved-taken branch indication from EXE.
REQ-007 i_mem_busy  in  1  SHALL be the data-memory wait request from MEM.
REQ-008 i_cnt_clr  in  1  SHALL be the synchronous clear for o_stall_cnt and o_stall_timeout.
REQ-009 o_pc_freeze  out  1  SHALL hold the PC register.
REQ-010 o_ifid_freeze  out  1  SHALL hold the IF/ID pipeline register.
REQ-011 o_ifid_flush  out  1  SHALL load a NOP into IF/ID.
REQ-012 o_idex_bubble  out  1  SHALL load a NOP into ID/EX.
REQ-013 o_mem_hold  out  1  SHALL hold the ID/EX, EX/MEM and MEM/WB registers.
REQ-014 o_state  out  2  SHALL expose the current state: RUN=0, HAZ_STALL=1, MEM_WAIT=2, FLUSH=3.
REQ-015 o_stall_cnt  out  CNT_W  SHALL count cycles with o_pc_freeze=1.
REQ-016 o_stall_timeout  out  1  SHALL be a sticky flag for a hazard stall that has lasted MAX_STALL cycles.

Function
REQ-017 Control outputs (REQ-009..013) SHALL be combinational from the current state and inputs, so they act in the same cycle the condition is presented (zero latency).
REQ-018 Priority SHALL be i_mem_busy > i_branch_taken > i_hazard_detected in every state.
REQ-019 RUN with i_mem_busy=1: pc_freeze, ifid_freeze and mem_hold SHALL be 1, bubble and flush 0; next state MEM_WAIT.
REQ-020 RUN with branch_taken=1 and mem_busy=0: ifid_flush and idex_bubble SHALL be 1, freezes 0; next state FLUSH.
REQ-021 RUN with hazard only: pc_freeze, ifid_freeze and idex_bubble SHALL be 1; next state HAZ_STALL.
REQ-022 RUN with no input asserted: all control outputs SHALL be 0; next state RUN.
REQ-023 HAZ_STALL SHALL apply the RUN rules (REQ-019..022), so a stall continues while hazard=1 and returns to RUN with outputs 0 in the first cycle hazard=0.
REQ-024 MEM_WAIT with mem_busy=1 SHALL hold the REQ-019 outputs and stay in MEM_WAIT; with mem_busy=0 it SHALL behave exactly as RUN for outputs and next state.
REQ-025 FLUSH SHALL last exactly one cycle and ignore i_hazard_detected (the ID slot holds a flushed bubble); it honours mem_busy and branch_taken per RUN rules, otherwise outputs 0 and next state RUN.
REQ-026 o_stall_cnt SHALL increment by 1 on every cycle with o_pc_freeze=1 and saturate at 2^CNT_W-1.
REQ-027 A consecutive hazard counter (8 bits) SHALL increment on each cycle where REQ-021 applies, reset to 0 on any other cycle, and saturate at MAX_STALL.
REQ-028 o_stall_timeout SHALL become 1 on the clock edge where the consecutive counter reaches MAX_STALL, and remain 1 until i_cnt_clr or reset.
REQ-029 i_cnt_clr=1 SHALL zero o_stall_cnt and o_stall_timeout on the next edge, taking precedence over an increment in the same cycle; the state machine is unaffected.

Reset
REQ-030 Asserting i_sys_rst_n=0 SHALL immediately force state RUN, o_stall_cnt=0, consecutive counter=0 and o_stall_timeout=0, including mid-stall or mid-MEM_WAIT.
REQ-031 During reset all control outputs SHALL be driven per RUN rules from the live inputs; the first edge after release operates from RUN.

Verification
REQ-032 Hazard pulsed 3 cycles from RUN -> pc_freeze, ifid_freeze and bubble =1 for exactly 3 cycles; state 0,1,1,1,0; o_stall_cnt=3.
REQ-033 Hazard and branch_taken asserted together in HAZ_STALL -> flush+bubble=1 and freezes=0 that cycle; next cycle state=3 with hazard still 1 -> all outputs 0; then state=0.
REQ-034 mem_busy 4 cycles overlapping a hazard -> mem_hold=1 and bubble=0 for 4 cycles; then the hazard stall resumes; the consecutive counter restarts from 0.
REQ-035 Hazard held 8 cycles with MAX_STALL=8 -> o_stall_timeout rises after the 8th edge and stays 1 after hazard drops; i_cnt_clr pulse -> timeout and o_stall_cnt both 0.
REQ-036 CNT_W=4 with freeze held 20 cycles -> o_stall_cnt stops at 15.
REQ-037 i_sys_rst_n low asynchronously in MEM_WAIT -> o_state=0 and counters=0 before the next clock edge.
